// File: rtl/step3.sv
// step3 -- final stage of the point-based backup.
//
// For every belief point p this block picks, among the N_ACTIONS candidate
// vectors produced by step2, the one with the largest dot product against
// the point's belief. It publishes that vector as the point's new alpha
// vector, together with the winning action index and the winning value.
// The search runs one (action, point) pair per cycle. Actions form the
// inner loop and points form the outer loop.
//
// Ports
//   clk                  rising-edge clock
//   rst_n                synchronous active-low reset
//   en                   start pulse; restarts the search from any state
//   gamma_action_bilief  [N_ACTIONS][N_POINTS][N_STATES] x W candidate vectors
//   point_belief         [N_POINTS][N_STATES] x W belief points
//   alpha_new            [N_POINTS][N_STATES] x W selected vector per point
//   action_sel           [N_POINTS] x 2 winning action index per point
//   value_sel            [N_POINTS] x (2W+1) winning dot product per point
//   busy                 high while loading or calculating
//   done                 one-cycle pulse after the last point is written
module step3 #(
  parameter int N_POINTS  = 16,
  parameter int N_ACTIONS = 3,
  parameter int N_STATES  = 2,
  parameter int W         = 16
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                en,
  input  logic [N_ACTIONS-1:0][N_POINTS-1:0][N_STATES-1:0][W-1:0] gamma_action_bilief,
  input  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0]            point_belief,
  output logic [N_POINTS-1:0][N_STATES-1:0][W-1:0]            alpha_new,
  output logic [N_POINTS-1:0][1:0]                            action_sel,
  output logic [N_POINTS-1:0][2*W:0]                          value_sel,
  output logic                                                busy,
  output logic                                                done
);

  localparam logic [3:0] P_LAST = 4'(N_POINTS - 1);
  localparam logic [1:0] A_LAST = 2'(N_ACTIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                                                  state_r;
  logic [N_ACTIONS-1:0][N_POINTS-1:0][N_STATES-1:0][W-1:0] g_r;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0]                b_r;
  logic [3:0]                                              p_r;
  logic [1:0]                                              a_r;
  logic [2*W:0]                                            best_val_r;
  logic [1:0]                                              best_a_r;

  logic [2*W:0]                                            dot_s;
  logic [2*W:0]                                            win_val_s;
  logic [1:0]                                              win_a_s;

  // Two-term dot product. Both products keep their full 2W bits, and the sum
  // keeps its carry, so no value is ever truncated.
  function automatic logic [2*W:0] dot2(
    input logic [N_STATES-1:0][W-1:0] g,
    input logic [N_STATES-1:0][W-1:0] b
  );
    logic [2*W-1:0] p0;
    logic [2*W-1:0] p1;
    p0 = {{W{1'b0}}, g[0]} * {{W{1'b0}}, b[0]};
    p1 = {{W{1'b0}}, g[1]} * {{W{1'b0}}, b[1]};
    return {1'b0, p0} + {1'b0, p1};
  endfunction

  // Running winner for the current point. The first action always seeds the
  // best value. A later action replaces it only when strictly larger, so a
  // tie keeps the lowest action index.
  always_comb begin
    dot_s = dot2(g_r[a_r][p_r], b_r[p_r]);
    if ((a_r == 2'd0) || (dot_s > best_val_r)) begin
      win_val_s = dot_s;
      win_a_s   = a_r;
    end else begin
      win_val_s = best_val_r;
      win_a_s   = best_a_r;
    end
  end

  // Control FSM, input snapshot, search counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      g_r        <= '0;
      b_r        <= '0;
      p_r        <= 4'd0;
      a_r        <= 2'd0;
      best_val_r <= '0;
      best_a_r   <= 2'd0;
      alpha_new  <= '0;
      action_sel <= '0;
      value_sel  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (en) begin
      // A start request from any state restarts the search. If the search was
      // about to finish, this also drops the pending done pulse.
      state_r    <= ST_LOAD;
      p_r        <= 4'd0;
      a_r        <= 2'd0;
      best_val_r <= '0;
      best_a_r   <= 2'd0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        ST_LOAD: begin
          g_r        <= gamma_action_bilief;
          b_r        <= point_belief;
          p_r        <= 4'd0;
          a_r        <= 2'd0;
          best_val_r <= '0;
          best_a_r   <= 2'd0;
          state_r    <= ST_CALC;
          busy       <= 1'b1;
          done       <= 1'b0;
        end
        ST_CALC: begin
          best_val_r <= win_val_s;
          best_a_r   <= win_a_s;
          if (a_r == A_LAST) begin
            // The last action for this point has been compared, so commit the result.
            alpha_new[p_r]  <= g_r[win_a_s][p_r];
            action_sel[p_r] <= win_a_s;
            value_sel[p_r]  <= win_val_s;
            a_r             <= 2'd0;
            if (p_r == P_LAST) begin
              p_r     <= 4'd0;
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              p_r  <= p_r + 4'd1;
              busy <= 1'b1;
              done <= 1'b0;
            end
          end else begin
            a_r  <= a_r + 2'd1;
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step3.sv
// Testbench for step3. It keeps a behavioural model that computes each point's
// argmax directly from the snapshot. The model tracks timing only as a count of
// search steps taken since the snapshot. One compare process checks every output
// against the model on each falling edge. Directed tests also check literal
// expected values.
module tb_step3;

  localparam int NP = 16;
  localparam int NA = 3;
  localparam int NS = 2;
  localparam int W  = 16;
  localparam int VW = 2 * W + 1;

  logic                                   clk;
  logic                                   rst_n;
  logic                                   en;
  logic [NA-1:0][NP-1:0][NS-1:0][W-1:0]   g_in;
  logic [NP-1:0][NS-1:0][W-1:0]           b_in;
  logic [NP-1:0][NS-1:0][W-1:0]           alpha_new;
  logic [NP-1:0][1:0]                     action_sel;
  logic [NP-1:0][VW-1:0]                  value_sel;
  logic                                   busy;
  logic                                   done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  step3 #(.N_POINTS(NP), .N_ACTIONS(NA), .N_STATES(NS), .W(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .gamma_action_bilief (g_in),
    .point_belief        (b_in),
    .alpha_new           (alpha_new),
    .action_sel          (action_sel),
    .value_sel           (value_sel),
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 idle, 1 loading, 2 searching, 3 finished
  int                              m_phase = 0;
  int                              m_step  = 0;
  logic [NP-1:0][NS-1:0][W-1:0]    r_alpha, m_alpha;
  logic [NP-1:0][1:0]              r_act,   m_act;
  logic [NP-1:0][VW-1:0]           r_val,   m_val;

  task automatic compute_results();
    logic [VW-1:0] d;
    logic [VW-1:0] best;
    int            ba;
    for (int p = 0; p < NP; p++) begin
      best = '0;
      ba   = 0;
      for (int a = 0; a < NA; a++) begin
        d = VW'(g_in[a][p][0]) * VW'(b_in[p][0]) + VW'(g_in[a][p][1]) * VW'(b_in[p][1]);
        if (a == 0 || d > best) begin
          best = d;
          ba   = a;
        end
      end
      r_val[p]   = best;
      r_act[p]   = 2'(ba);
      r_alpha[p] = g_in[ba][p];
    end
  endtask

  initial begin
    m_alpha = '0; m_act = '0; m_val = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase = 0;
        m_alpha = '0; m_act = '0; m_val = '0;
      end else if (en) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        compute_results();
        m_phase = 2;
        m_step  = 0;
      end else if (m_phase == 2) begin
        m_step++;
        if (m_step % NA == 0) begin
          m_alpha[m_step / NA - 1] = r_alpha[m_step / NA - 1];
          m_act[m_step / NA - 1]   = r_act[m_step / NA - 1];
          m_val[m_step / NA - 1]   = r_val[m_step / NA - 1];
        end
        if (m_step == NP * NA) m_phase = 3;
      end else begin
        m_phase = 0;
      end
    end
  end

  // Compare the outputs against the model on every falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", 528'(busy), 528'(m_phase == 1 || m_phase == 2));
      chk("done", 528'(done), 528'(m_phase == 3));
      chk("alpha_new", 528'(alpha_new), 528'(m_alpha));
      chk("action_sel", 528'(action_sel), 528'(m_act));
      chk("value_sel", 528'(value_sel), 528'(m_val));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_en();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  // Counts falling edges after the en edge until done; busy cycles are tallied.
  task automatic wait_done(input string name, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) break;
    end
    if (!done) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, lat);
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < NA; a++)
      for (int p = 0; p < NP; p++)
        for (int s = 0; s < NS; s++)
          g_in[a][p][s] = 16'($urandom);
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++)
        b_in[p][s] = 16'($urandom);
  endtask

  int lat;
  int bcnt;
  logic [NP-1:0][VW-1:0] all_max;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    g_in  = '1;
    b_in  = '1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Test 1: all inputs 0xFFFF.
    pulse_en();
    wait_done("t1", lat, bcnt);
    chk("t1_latency", 528'(lat), 528'(50));
    chk("t1_busy_cycles", 528'(bcnt), 528'(49));
    for (int p = 0; p < NP; p++) all_max[p] = 33'h1_FFFC_0002;
    chk("t1_value_sel", 528'(value_sel), 528'(all_max));
    chk("t1_action_sel", 528'(action_sel), 528'(0));
    @(negedge clk);
    chk("t1_done_one_cycle", 528'(done), 528'(0));
    tick();

    // Test 2: directed argmax on point 5 and a three-way tie on point 0.
    g_in = '0;
    b_in = '0;
    b_in[5][0] = 16'd1; b_in[5][1] = 16'd2;
    g_in[0][5][0] = 16'd3; g_in[0][5][1] = 16'd1;
    g_in[1][5][0] = 16'd1; g_in[1][5][1] = 16'd3;
    g_in[2][5][0] = 16'd2; g_in[2][5][1] = 16'd2;
    b_in[0][0] = 16'd1; b_in[0][1] = 16'd1;
    g_in[0][0][0] = 16'd2; g_in[0][0][1] = 16'd2;
    g_in[1][0][0] = 16'd4; g_in[1][0][1] = 16'd0;
    g_in[2][0][0] = 16'd0; g_in[2][0][1] = 16'd4;
    pulse_en();
    wait_done("t2", lat, bcnt);
    chk("t2_act5", 528'(action_sel[5]), 528'(1));
    chk("t2_alpha5", 528'(alpha_new[5]), 528'({16'd3, 16'd1}));
    chk("t2_val5", 528'(value_sel[5]), 528'(7));
    chk("t2_tie_act0", 528'(action_sel[0]), 528'(0));
    chk("t2_tie_alpha0", 528'(alpha_new[0]), 528'({16'd2, 16'd2}));
    chk("t2_tie_val0", 528'(value_sel[0]), 528'(4));
    chk("t2_val3", 528'(value_sel[3]), 528'(0));
    chk("t2_act3", 528'(action_sel[3]), 528'(0));
    tick();

    // Test 3: inputs change right after LOAD; results follow the snapshot.
    fill_random();
    pulse_en();
    tick();
    fill_random();
    wait_done("t3", lat, bcnt);
    chk("t3_latency", 528'(lat), 528'(49));
    tick();

    // Test 4: restart mid-calculation with a new input set.
    fill_random();
    pulse_en();
    repeat (21) tick();
    fill_random();
    pulse_en();
    wait_done("t4", lat, bcnt);
    chk("t4_latency", 528'(lat), 528'(50));
    tick();

    // Test 5: synchronous reset mid-calculation, then a normal run.
    fill_random();
    pulse_en();
    repeat (31) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_value_sel", 528'(value_sel), 528'(0));
    chk("t5_rst_alpha", 528'(alpha_new), 528'(0));
    chk("t5_rst_busy", 528'(busy), 528'(0));
    tick();
    pulse_en();
    wait_done("t5", lat, bcnt);
    chk("t5_latency", 528'(lat), 528'(50));
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
